// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for the EX stage (DIV/DIVU).
// Result is {remainder, quotient}; stallreq holds the pipe while busy.
module div_iter #(
   parameter int W = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           signed_div,
   input  logic [W-1:0]   div_a,
   input  logic [W-1:0]   div_b,
   input  logic           annul,
   output logic [2*W-1:0] result,
   output logic           ready,
   output logic           stallreq
);

   localparam int CW = $clog2(W + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DBZ,
      S_ON,
      S_END
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W:0]     rem_q, rem_d;
   logic [W-1:0]   quo_q, quo_d;
   logic [W-1:0]   dvs_q, dvs_d;
   logic           negq_q, negq_d;
   logic           negr_q, negr_d;
   logic [2*W-1:0] res_q, res_d;
   logic           rdy_q, rdy_d;
   logic           blk_q, blk_d;

   logic [W-1:0]   abs_a, abs_b;
   logic [W+1:0]   shifted, trial;
   logic [W:0]     rem_n;
   logic [W-1:0]   quo_n;
   logic [W-1:0]   q_fix, r_fix;
   logic           qbit;

   // Magnitudes, one restoring step, and the sign fixup of the final step
   always_comb begin
      abs_a   = (signed_div & div_a[W-1]) ? -div_a : div_a;
      abs_b   = (signed_div & div_b[W-1]) ? -div_b : div_b;
      shifted = {rem_q, quo_q[W-1]};
      trial   = shifted - {2'b00, dvs_q};
      qbit    = ~trial[W+1];
      rem_n   = qbit ? trial[W:0] : shifted[W:0];
      quo_n   = {quo_q[W-2:0], qbit};
      q_fix   = negq_q ? -quo_n : quo_n;
      r_fix   = negr_q ? -rem_n[W-1:0] : rem_n[W-1:0];
   end

   // Next-state and datapath control; annul overrides everything
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      res_d   = res_q;
      rdy_d   = rdy_q;
      blk_d   = blk_q;
      case (state_q)
         S_IDLE: begin
            if (!start) blk_d = 1'b0;
            if (start && !blk_q) begin
               if (div_b == '0) begin
                  state_d = S_DBZ;
               end else begin
                  state_d = S_ON;
                  cnt_d   = '0;
                  rem_d   = '0;
                  quo_d   = abs_a;
                  dvs_d   = abs_b;
                  negq_d  = signed_div & (div_a[W-1] ^ div_b[W-1]);
                  negr_d  = signed_div & div_a[W-1];
               end
            end
         end
         S_DBZ: begin
            state_d = S_END;
            res_d   = '0;
            rdy_d   = 1'b1;
         end
         S_ON: begin
            rem_d = rem_n;
            quo_d = quo_n;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
               state_d = S_END;
               res_d   = {r_fix, q_fix};
               rdy_d   = 1'b1;
            end
         end
         S_END: begin
            if (!start) begin
               state_d = S_IDLE;
               res_d   = '0;
               rdy_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (annul) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         res_d   = '0;
         rdy_d   = 1'b0;
         blk_d   = 1'b1;
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         res_q   <= '0;
         rdy_q   <= 1'b0;
         blk_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         res_q   <= res_d;
         rdy_q   <= rdy_d;
         blk_q   <= blk_d;
      end
   end

   assign result   = res_q;
   assign ready    = rdy_q;
   assign stallreq = start & ~rdy_q;

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: random and directed DIV/DIVU
// against an arithmetic reference, plus annul/reset aborts.
module tb_div_iter;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        signed_div;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic        annul;
   logic [63:0] result;
   logic        ready;
   logic        stallreq;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [63:0] res;
      int          lat;
      int          c0;
   } exp_t;

   exp_t sbq[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   div_iter dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .signed_div (signed_div),
      .div_a      (div_a),
      .div_b      (div_b),
      .annul      (annul),
      .result     (result),
      .ready      (ready),
      .stallreq   (stallreq)
   );

   function automatic exp_t model(bit sg, logic [31:0] a,
                                  logic [31:0] b, int c0);
      exp_t   e;
      longint sa, sb, q, r;
      e.c0 = c0;
      if (b == 0) begin
         e.res = '0;
         e.lat = 2;
      end else begin
         e.lat = 33;
         if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
         end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
         end
         q = sa / sb;
         r = sa % sb;
         e.res = {r[31:0], q[31:0]};
      end
      return e;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on each rising ready
   logic prev_rdy = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         chk("stallreq", {63'd0, stallreq}, {63'd0, start & ~ready});
         if (!ready) chk("result_not_ready", result, 64'd0);
         if (ready && !prev_rdy) begin
            if (sbq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_ready: got result %h expected no ready",
                        result);
            end else begin
               e = sbq.pop_front();
               chk("result", result, e.res);
               chk("latency", 64'(cyc - e.c0), 64'(e.lat));
            end
         end
      end
      prev_rdy = ready;
   end

   // All driver tasks start and end just after a rising edge
   task automatic do_op(bit sg, logic [31:0] a, logic [31:0] b, bit mid);
      int  c0;
      int  n;
      bit  seen;
      c0 = cyc;
      signed_div = sg;
      div_a = a;
      div_b = b;
      start = 1'b1;
      sbq.push_back(model(sg, a, b, c0));
      seen = 1'b0;
      n = 0;
      while (!seen && n < 100) begin
         @(posedge clk);
         #1;
         n++;
         if (mid && cyc == c0 + 5) begin
            div_a = $urandom;
            div_b = $urandom;
            signed_div = ~sg;
         end
         if (ready) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL timeout: got no ready expected ready within 100 cycles");
         void'(sbq.pop_back());
      end
      start = 1'b0;
      @(posedge clk);
      #1;
      chk("drop_ready", {63'd0, ready}, 64'd0);
   endtask

   task automatic abort_op(bit use_rst, int at);
      int c0;
      c0 = cyc;
      signed_div = 1'b0;
      div_a = 32'd100;
      div_b = 32'd7;
      start = 1'b1;
      while (cyc < c0 + at) begin
         @(posedge clk);
         #1;
      end
      if (use_rst) rst = 1'b1;
      else annul = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      annul = 1'b0;
      start = 1'b0;
      chk("abort_ready", {63'd0, ready}, 64'd0);
      chk("abort_result", result, 64'd0);
      @(posedge clk);
      #1;
      do_op(1'b0, 32'd50, 32'd5, 1'b0);
   endtask

   initial begin
      bit          sg;
      logic [31:0] a, b;
      rst = 1'b1;
      start = 1'b0;
      signed_div = 1'b0;
      div_a = '0;
      div_b = '0;
      annul = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_ready", {63'd0, ready}, 64'd0);
      chk("reset_result", result, 64'd0);
      chk("reset_stall", {63'd0, stallreq}, 64'd0);

      do_op(1'b0, 32'd100, 32'd7, 1'b0);
      do_op(1'b1, 32'hFFFFFFF9, 32'h2, 1'b0);
      do_op(1'b1, 32'h7, 32'hFFFFFFFE, 1'b0);
      do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      do_op(1'b0, 32'hFFFFFFFF, 32'h1, 1'b0);
      do_op(1'b0, 32'h12345, 32'h0, 1'b0);
      do_op(1'b1, 32'h80000000, 32'h0, 1'b0);
      abort_op(1'b0, 10);
      abort_op(1'b1, 20);
      do_op(1'b0, 32'd1000, 32'd7, 1'b1);
      do_op(1'b1, 32'hFFFFFC18, 32'd7, 1'b1);

      for (int i = 0; i < 24; i++) begin
         sg = 1'($urandom_range(0, 1));
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 15));
            2: b = $urandom;
            default: b = -32'($urandom_range(1, 9));
         endcase
         do_op(sg, a, b, 1'b0);
      end

      repeat (2) @(posedge clk);
      #1;
      chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Iterative restoring divider for the EX stage; executes DIV/DIVU over multiple cycles.
- Its 64-bit result (remainder→HI, quotient→LO) drives the EX-stage HI/LO write data and write enables consumed by the HI/LO register block.
- Holds the pipeline via stallreq while busy.
- One radix-2 iteration per clock.

Parameters:
- W, 32, operand width; iteration count equals W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  divide request from EX decode; held high until ready is seen
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU
- div_a  in  W  dividend
- div_b  in  W  divisor
- annul  in  1  abort in-flight operation (exception/flush)
- result  out  2W  {remainder, quotient}; valid only while ready=1
- ready  out  1  result valid
- stallreq  out  1  pipeline stall request = start & ~ready (combinational)

Behaviour:
- States:
  - IDLE: start=1 and div_b==0 goes to DBZ. Start=1 and div_b!=0 latches the operands, cnt=0, and goes to ON.
  - DBZ: goes to END unconditionally, with result=0.
  - ON: one iteration per cycle. cnt increments. After the W-th iteration edge, applies sign fixup, latches result, and goes to END.
  - END: ready=1. When start=0 on a clock edge, goes to IDLE and clears ready and result to 0 on the same edge.
- Operand capture:
  - div_a, div_b and signed_div are sampled only on the IDLE→ON edge.
  - Input changes during ON or END are ignored.
- Signed mode:
  - Operands are converted to magnitudes before iterating.
  - The quotient is negated iff the operand signs differ.
  - The remainder takes the sign of the dividend.
  - The magnitude of 0x80000000 is treated as unsigned 2^31 (no overflow fault).
- Iteration:
  - The partial remainder is W+1 bits wide.
  - Trial subtract; if the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
- Latency, with start first high in cycle 0 (state IDLE):
  - Normal divide: ready=1 from cycle W+1 (33 for W=32).
  - Divide by zero: ready=1 from cycle 2.
  - stallreq is high in cycles 0..W and 0 once ready=1.
- Annul:
  - annul=1 in any state forces IDLE on the next edge, with result=0, ready=0 and cnt=0.
  - annul has priority over start in IDLE.
  - After annul, start must be low for one cycle before a new operation is accepted.
- Reset: rst=1 forces IDLE with result=0, ready=0 and cnt=0, including mid-operation. All outputs are 0 the cycle after reset.
- Back-to-back operations: a new start is accepted only from IDLE, so at least one start=0 cycle separates operations.
- Outputs in IDLE, DBZ and ON: result=0, ready=0.

Test Plan:
- DIVU 100/7: start=1 held → ready first high in cycle 33; result={0x00000002, 0x0000000E}; stallreq high cycles 0..32.
- DIV -7/2 (0xFFFFFFF9/0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 7/-2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. DIVU 0xFFFFFFFF/1 → quotient 0xFFFFFFFF, remainder 0.
- Divide by zero (div_b=0) → ready in cycle 2, result 0. Drop start → ready=0 and IDLE next cycle.
- Annul at cycle 10 of ON → cycle 11: IDLE, ready=0, result=0. Restart with 50/5 → quotient 10, remainder 0 after the full latency. Repeat with rst=1 at cycle 20 → same clean restart.
- Change div_a/div_b mid-operation (cycle 5) → result still reflects the operands sampled at cycle 0.
